imem_program_loader: RTL and testbench

// - Boot-time loader upstream of the mips core: receives a byte-serial program image, packs it into 32-bit words,

---
 rtl/imem_program_loader_pkg.sv | 26 ++
 rtl/imem_program_loader_if.sv | 24 ++
 rtl/imem_program_loader_word_assembler.sv | 43 ++++
 rtl/imem_program_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_program_loader_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned HDR_BYTES       = 2;
  localparam int unsigned DEF_IM_DEPTH    = 256;
  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT     = 1024;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic accepts_bytes(input state_e s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_program_loader_if #(
  parameter int unsigned AW = 8
) ();
  import imem_program_loader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [AW-1:0]     im_addr;
  logic [WORD_W-1:0] im_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/imem_program_loader_word_assembler.sv
// Packs four little-endian bytes into a word; word_valid pulses one cycle
// after the fourth byte is strobed in.
module imem_program_loader_word_assembler
  import imem_program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              pc_rst,
  input  logic              strobe,
  input  logic              clr,
  input  logic [BYTE_W-1:0] data,
  output logic [1:0]        byte_idx,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-BYTE_W-1:0] pack;

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      byte_idx   <= 2'd0;
      pack       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        byte_idx <= 2'd0;
      end else if (strobe) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    pack[7:0]   <= data;
          2'd1:    pack[15:8]  <= data;
          2'd2:    pack[23:16] <= data;
          default: begin
            word       <= {data, pack};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time loader: takes a byte-serial image (16-bit LE count, then LE words),
// writes it into instruction memory and only then releases the core reset.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned IM_DEPTH    = DEF_IM_DEPTH,
  parameter int unsigned IM_AW       = $clog2(IM_DEPTH),
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 pc_rst,
  imem_program_loader_if.master bus,
  input  logic                 reload,
  output logic                 cpu_rst,
  output logic                 load_done,
  output logic                 err_size,
  output logic                 err_timeout
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_e            state;
  state_e            next_state;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  word_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IM_AW-1:0]  addr_q;

  logic [1:0]        byte_idx;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  logic              xfer_c;
  logic              in_load_c;
  logic              abort_c;
  logic              word_end_c;
  logic              last_byte_c;
  logic              last_write_c;
  logic              asm_clr_c;
  logic [CNT_W-1:0]  n_full_c;

  logic rx_ready_d;
  logic cpu_rst_d;
  logic load_done_d;
  logic err_size_d;
  logic err_timeout_d;

  assign bus.im_we    = word_valid;
  assign bus.im_wdata = word;
  assign bus.im_addr  = addr_q;

  // Transfer qualifiers shared by the FSM and the datapath.
  always_comb begin
    xfer_c       = bus.rx_valid & bus.rx_ready;
    in_load_c    = (state == S_HDR1) || (state == S_DATA);
    n_full_c     = {bus.rx_data, n[7:0]};
    abort_c      = in_load_c && !xfer_c && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    word_end_c   = xfer_c && (state == S_DATA) && (byte_idx == 2'd3);
    last_byte_c  = word_end_c && (word_cnt == n - CNT_W'(1));
    last_write_c = word_valid && (word_cnt + CNT_W'(1) == n);
    asm_clr_c    = abort_c || ((state == S_RUN) && reload);
  end

  imem_program_loader_word_assembler u_asm (
    .clk        (clk),
    .pc_rst     (pc_rst),
    .strobe     (xfer_c && (state == S_DATA)),
    .clr        (asm_clr_c),
    .data       (bus.rx_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) state <= S_HDR0;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_HDR0: if (xfer_c) next_state = S_HDR1;
      S_HDR1: begin
        if (xfer_c) begin
          if (n_full_c == '0)                         next_state = S_HOLD;
          else if (n_full_c > CNT_W'(IM_DEPTH))       next_state = S_ERR;
          else                                        next_state = S_DATA;
        end else if (abort_c) begin
          next_state = S_HDR0;
        end
      end
      S_DATA: begin
        if (abort_c)           next_state = S_HDR0;
        else if (last_write_c) next_state = S_HOLD;
      end
      S_HOLD: if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) next_state = S_RUN;
      S_RUN:  if (reload) next_state = S_HDR0;
      S_ERR:  next_state = S_ERR;
      default: next_state = S_HDR0;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    rx_ready_d    = 1'b0;
    cpu_rst_d     = 1'b1;
    load_done_d   = 1'b0;
    err_size_d    = err_size;
    err_timeout_d = 1'b0;
    rx_ready_d    = accepts_bytes(next_state) && !last_byte_c;
    cpu_rst_d     = (next_state != S_RUN);
    load_done_d   = (next_state == S_RUN);
    err_timeout_d = abort_c;
    if ((state == S_HDR1) && (next_state == S_ERR)) err_size_d = 1'b1;
    else if ((state == S_RUN) && reload)            err_size_d = 1'b0;
  end

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      bus.rx_ready <= 1'b0;
      cpu_rst      <= 1'b1;
      load_done    <= 1'b0;
      err_size     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      bus.rx_ready <= rx_ready_d;
      cpu_rst      <= cpu_rst_d;
      load_done    <= load_done_d;
      err_size     <= err_size_d;
      err_timeout  <= err_timeout_d;
    end
  end

  // Header latch, word/hold/idle counters and the write address.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      n        <= '0;
      word_cnt <= '0;
      hold_cnt <= '0;
      idle_cnt <= '0;
      addr_q   <= '0;
    end else begin
      if ((state == S_HDR0) && xfer_c) n[7:0]  <= bus.rx_data;
      if ((state == S_HDR1) && xfer_c) n[15:8] <= bus.rx_data;

      if (in_load_c && !xfer_c && !abort_c) idle_cnt <= idle_cnt + IDLE_W'(1);
      else                                  idle_cnt <= '0;

      if (state == S_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                 hold_cnt <= '0;

      if ((state != S_DATA) || abort_c) word_cnt <= '0;
      else if (word_valid)              word_cnt <= word_cnt + CNT_W'(1);

      if (word_end_c) addr_q <= word_cnt[IM_AW-1:0];
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: images are generated at random or
// from fixed cases, expected writes are queued and checked by a monitor.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  localparam int unsigned IM_DEPTH    = 256;
  localparam int unsigned IM_AW       = 8;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int unsigned TIMEOUT     = 1024;

  typedef struct packed {
    logic [IM_AW-1:0] addr;
    logic [31:0]      data;
  } wr_t;
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk = 1'b0;
  logic pc_rst;
  logic reload;
  logic cpu_rst;
  logic load_done;
  logic err_size;
  logic err_timeout;

  imem_program_loader_if #(.AW(IM_AW)) bus ();

  imem_program_loader #(
    .IM_DEPTH    (IM_DEPTH),
    .IM_AW       (IM_AW),
    .HOLD_CYCLES (HOLD_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .pc_rst      (pc_rst),
    .bus         (bus),
    .reload      (reload),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .err_size    (err_size),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_xfer_cyc = 0;
  int   last_we_cyc = 0;
  int   fall_cyc = 0;
  int   to_cyc = 0;
  int   n_to = 0;
  int   n_writes = 0;
  logic prev_cpu_rst = 1'b1;
  wr_t  exp_q[$];
  wr_t  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and tracks transfer, reset-release and timeout timing.
  always @(negedge clk) begin
    cyc++;
    if (!pc_rst) begin
      if (bus.im_we) begin
        n_writes++;
        last_we_cyc = cyc;
        check("we_latency", 32'(cyc - last_xfer_cyc), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.im_addr, bus.im_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.im_addr), 32'(mon_e.addr));
          check("wr_data", bus.im_wdata, mon_e.data);
        end
      end
      if (bus.rx_valid && bus.rx_ready) last_xfer_cyc = cyc;
      if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
      if (err_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
    end
    prev_cpu_rst = cpu_rst;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference image encoding: little-endian count, then little-endian words.
  function automatic byte_q_t image_bytes(input logic [15:0] n, input word_q_t w);
    byte_q_t q;
    for (int k = 0; k < int'(HDR_BYTES); k++) q.push_back(8'(n >> (8 * k)));
    foreach (w[i]) for (int k = 0; k < 4; k++) q.push_back(8'(w[i] >> (8 * k)));
    return q;
  endfunction

  task automatic expect_words(input word_q_t w);
    foreach (w[i]) exp_q.push_back('{addr: IM_AW'(i), data: w[i]});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && guard < 64) begin
      tick(1);
      guard++;
    end
    if (!bus.rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_wait: got rx_ready 0 after %0d cycles expected 1", guard);
      bus.rx_valid = 1'b0;
      return;
    end
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t q, input int count, input int gap_max);
    for (int i = 0; i < count && i < q.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          bus.rx_valid = 1'b0;
          tick(1);
        end
      end
      send_byte(q[i]);
    end
  endtask

  task automatic wait_run(input string name, input bit had_writes);
    int g = 0;
    while (!load_done && g < 200) begin
      tick(1);
      g++;
    end
    tick(1);
    check({name, "_load_done"}, 32'(load_done), 32'd1);
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    if (had_writes) check({name, "_hold"}, 32'(fall_cyc - last_we_cyc), 32'(HOLD_CYCLES + 1));
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reload(input string name);
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
    check({name, "_reload_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({name, "_reload_done"}, 32'(load_done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({name, "_im_we"}, 32'(bus.im_we), 32'd0);
    check({name, "_im_addr"}, 32'(bus.im_addr), 32'd0);
    check({name, "_im_wdata"}, bus.im_wdata, 32'd0);
    check({name, "_load_done"}, 32'(load_done), 32'd0);
    check({name, "_err_size"}, 32'(err_size), 32'd0);
    check({name, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t w;
    byte_q_t q;
    int      n;
    int      n_to0;
    int      g;
    int      wr0;

    pc_rst       = 1'b1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(3);
    check_reset_outputs("reset");
    pc_rst = 1'b0;
    check("reset_first_ready", 32'(bus.rx_ready), 32'd0);
    tick(1);
    check("reset_ready_up", 32'(bus.rx_ready), 32'd1);

    // Two-word image, back-to-back bytes.
    w = '{32'h2008_0005, 32'h0109_4020};
    expect_words(w);
    send_bytes(image_bytes(16'd2, w), 10, 0);
    wait_run("two_words", 1'b1);

    // Reload in RUN, then a single word.
    do_reload("reload");
    w = '{32'hDEAD_BEEF};
    expect_words(w);
    send_bytes(image_bytes(16'd1, w), 6, 0);
    wait_run("reload_img", 1'b1);

    // Empty image: no writes, core released after HOLD.
    do_reload("empty");
    wr0 = n_writes;
    w = {};
    send_bytes(image_bytes(16'd0, w), 2, 0);
    wait_run("empty_img", 1'b0);
    check("empty_no_writes", 32'(n_writes - wr0), 32'd0);

    // Randomized images with random byte gaps.
    for (int it = 0; it < 5; it++) begin
      do_reload("rand");
      n = int'($urandom_range(8, 1));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      expect_words(w);
      q = image_bytes(16'(n), w);
      send_bytes(q, q.size(), 3);
      wait_run("rand_img", 1'b1);
    end

    // Largest legal image fills every address.
    do_reload("full");
    w = {};
    for (int i = 0; i < int'(IM_DEPTH); i++) w.push_back($urandom);
    expect_words(w);
    q = image_bytes(16'(IM_DEPTH), w);
    send_bytes(q, q.size(), 0);
    wait_run("full_img", 1'b1);

    // Stall mid-image: one timeout pulse, back to header, then a fresh image.
    do_reload("timeout");
    w = '{$urandom, $urandom, $urandom};
    exp_q.push_back('{addr: '0, data: w[0]});
    n_to0 = n_to;
    send_bytes(image_bytes(16'd3, w), 6, 0);
    g = 0;
    while (n_to == n_to0 && g < int'(TIMEOUT) + 50) begin
      tick(1);
      g++;
    end
    tick(3);
    check("timeout_pulses", 32'(n_to - n_to0), 32'd1);
    check("timeout_delay", 32'(to_cyc - last_xfer_cyc), 32'(TIMEOUT + 1));
    check("timeout_pulse_ended", 32'(err_timeout), 32'd0);
    check("timeout_hdr0_ready", 32'(bus.rx_ready), 32'd1);
    check("timeout_cpu_rst", 32'(cpu_rst), 32'd1);
    w = '{$urandom};
    expect_words(w);
    send_bytes(image_bytes(16'd1, w), 6, 0);
    wait_run("after_timeout", 1'b1);

    // Reset while at byte 2 of word 1.
    do_reload("abort");
    w = '{$urandom, $urandom};
    exp_q.push_back('{addr: '0, data: w[0]});
    send_bytes(image_bytes(16'd2, w), 8, 0);
    pc_rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    check("abort_drained", 32'(exp_q.size()), 32'd0);
    tick(2);
    pc_rst = 1'b0;
    tick(1);

    // Reset right after a fourth byte drops the pending write.
    wr0 = n_writes;
    w = '{$urandom};
    send_bytes(image_bytes(16'd1, w), 6, 0);
    pc_rst = 1'b1;
    #1;
    check("drop_im_we", 32'(bus.im_we), 32'd0);
    tick(2);
    pc_rst = 1'b0;
    tick(3);
    check("drop_no_write", 32'(n_writes - wr0), 32'd0);

    // Oversized header: terminal error, reload ignored.
    send_bytes(image_bytes(16'(IM_DEPTH + 1), word_q_t'{}), 2, 0);
    tick(1);
    check("size_err", 32'(err_size), 32'd1);
    check("size_ready", 32'(bus.rx_ready), 32'd0);
    check("size_cpu_rst", 32'(cpu_rst), 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    reload = 1'b1;
    tick(2);
    reload = 1'b0;
    tick(30);
    bus.rx_valid = 1'b0;
    check("size_err_sticky", 32'(err_size), 32'd1);
    check("size_cpu_rst_held", 32'(cpu_rst), 32'd1);
    check("size_not_done", 32'(load_done), 32'd0);
    check("size_no_writes", 32'(n_writes - wr0), 32'd0);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
